sync_tp_ram_fifo_ctrl: RTL and testbench

Stream-FIFO controller sitting directly upstream of the team's synchronous two-port RAM.
- Accepts a valid/ready input stream and generates the RAM write-port and read-port controls.
- Tracks the RAM's fixed read latency and captures returning read data into a small prefetch buffer.
- Presents the buffered data as a valid/ready output stream at full throughput (one word per cycle).

---
 rtl/sync_tp_ram_fifo_ctrl_pkg.sv | 20 ++
 rtl/sync_tp_ram_fifo_obuf.sv | 84 ++++++++
 rtl/sync_tp_ram_fifo_ctrl.sv | 145 ++++++++++++++
 tb/tb_sync_tp_ram_fifo_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_tp_ram_fifo_ctrl_pkg.sv
// Shared definitions for the two-port-RAM stream FIFO controller.
//   RAM_LAT_*  : legal RAM read latencies (1 = no RAM output regs, 2 = output regs)
//   ob_depth() : prefetch buffer depth needed to cover the RAM read latency
//   ptr_inc()  : pointer increment with explicit wrap at an arbitrary depth
package sync_tp_ram_fifo_ctrl_pkg;

    localparam int unsigned RAM_LAT_NO_OREG = 1;
    localparam int unsigned RAM_LAT_OREG    = 2;

    // One slot per in-flight read plus one for the word being presented.
    function automatic int unsigned ob_depth(input int unsigned ram_latency);
        return ram_latency + 1;
    endfunction

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_tp_ram_fifo_obuf.sv
// Small register FIFO holding words returned by the RAM until the consumer takes them.
// Ports:
//   Clk_CI, Rst_RBI   clock, asynchronous active-low reset
//   Clr_SI            synchronous clear (drops all entries, wins over push)
//   Push_SI           write PushData_DI at the tail
//   Pop_SI            drop the head entry (ignored when empty)
//   Cnt_DO            number of entries held
//   HeadData_DO       head entry, driven from registers
module sync_tp_ram_fifo_obuf
    import sync_tp_ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  Clr_SI,
    input  logic                  Push_SI,
    input  logic [DATA_WIDTH-1:0] PushData_DI,
    input  logic                  Pop_SI,
    output logic [CNT_WIDTH-1:0]  Cnt_DO,
    output logic [DATA_WIDTH-1:0] HeadData_DO
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  full;
    logic                  do_pop;

    assign full   = (cnt_q == CNT_WIDTH'(DEPTH));
    assign do_pop = Pop_SI && (cnt_q != '0);

    always_comb begin
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        cnt_d    = cnt_q + CNT_WIDTH'(Push_SI) - CNT_WIDTH'(do_pop);
        if (Push_SI) begin
            wr_idx_d = IDX_W'(ptr_inc(32'(wr_idx_q), DEPTH));
        end
        if (do_pop) begin
            rd_idx_d = IDX_W'(ptr_inc(32'(rd_idx_q), DEPTH));
        end
        if (Clr_SI) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (Push_SI && !Clr_SI) begin
            mem_q[wr_idx_q] <= PushData_DI;
        end
    end

    assign Cnt_DO      = cnt_q;
    assign HeadData_DO = mem_q[rd_idx_q];

    // The controller's read credits must keep this from ever happening.
    push_when_full_a: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
                                       !(Push_SI && full));

endmodule

// File: rtl/sync_tp_ram_fifo_ctrl.sv
// Stream FIFO controller in front of a synchronous two-port RAM.
// Ports:
//   Clk_CI, Rst_RBI                     clock, asynchronous active-low reset
//   Clr_SI                              synchronous clear, empties the FIFO
//   InValid_SI, InReady_SO, InData_DI   input stream
//   OutValid_SO, OutReady_SI, OutData_DO output stream (from the prefetch buffer)
//   RamWrEn_SO, RamWrAddr_DO, RamWrData_DO  RAM write port
//   RamRdEn_SO, RamRdAddr_DO, RamRdData_DI  RAM read port (data RAM_LATENCY cycles after enable)
//   Fill_DO                             words held: RAM + in flight + prefetch buffer
module sync_tp_ram_fifo_ctrl
    import sync_tp_ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_DEPTH  = 1024,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  Clr_SI,
    input  logic                  InValid_SI,
    output logic                  InReady_SO,
    input  logic [DATA_WIDTH-1:0] InData_DI,
    output logic                  OutValid_SO,
    input  logic                  OutReady_SI,
    output logic [DATA_WIDTH-1:0] OutData_DO,
    output logic                  RamWrEn_SO,
    output logic [ADDR_WIDTH-1:0] RamWrAddr_DO,
    output logic [DATA_WIDTH-1:0] RamWrData_DO,
    output logic                  RamRdEn_SO,
    output logic [ADDR_WIDTH-1:0] RamRdAddr_DO,
    input  logic [DATA_WIDTH-1:0] RamRdData_DI,
    output logic [ADDR_WIDTH+1:0] Fill_DO
);

    localparam int unsigned OB_DEPTH = ob_depth(RAM_LATENCY);
    localparam int unsigned OB_CNT_W = $clog2(OB_DEPTH + 1);
    localparam int unsigned OCC_W    = OB_CNT_W + 1;
    localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
    localparam int unsigned FILL_W   = ADDR_WIDTH + 2;

    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       ram_cnt_q, ram_cnt_d;
    logic [RAM_LATENCY-1:0] inflight_q, inflight_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [OB_CNT_W-1:0]    ob_cnt;
    logic [OB_CNT_W-1:0]    inflight_cnt;
    logic [OCC_W-1:0]       occ;
    logic                   in_xfer;
    logic                   out_pop;
    logic                   rd_issue;

    assign InReady_SO  = (ram_cnt_q < CNT_W'(DATA_DEPTH)) && !Clr_SI;
    assign in_xfer     = InValid_SI && InReady_SO;
    assign OutValid_SO = (ob_cnt != '0);
    assign out_pop     = OutValid_SO && OutReady_SI;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < int'(RAM_LATENCY); i++) begin
            inflight_cnt = inflight_cnt + OB_CNT_W'(inflight_q[i]);
        end
    end

    // Buffer slots committed after this edge. The slot freed by a pop in this
    // cycle is reusable immediately, which closes the credit loop in
    // RAM_LATENCY+1 cycles and keeps one word per cycle with OB_DEPTH slots.
    // A pop implies ob_cnt > 0, so this cannot underflow.
    assign occ      = OCC_W'(ob_cnt) + OCC_W'(inflight_cnt) - OCC_W'(out_pop);
    // ram_cnt_q excludes the word written this cycle, so a read never
    // targets the address being written.
    assign rd_issue = (ram_cnt_q != '0) && (occ < OCC_W'(OB_DEPTH)) && !Clr_SI;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q + CNT_W'(in_xfer) - CNT_W'(rd_issue);
        fill_d     = fill_q + FILL_W'(in_xfer) - FILL_W'(out_pop);
        inflight_d = '0;
        inflight_d[0] = rd_issue;
        for (int i = 1; i < int'(RAM_LATENCY); i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
        if (in_xfer) begin
            wr_ptr_d = ADDR_WIDTH'(ptr_inc(32'(wr_ptr_q), DATA_DEPTH));
        end
        if (rd_issue) begin
            rd_ptr_d = ADDR_WIDTH'(ptr_inc(32'(rd_ptr_q), DATA_DEPTH));
        end
        if (Clr_SI) begin
            // Zeroing the in-flight valids discards data still returning from the RAM.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ram_cnt_d  = '0;
            fill_d     = '0;
            inflight_d = '0;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            fill_q     <= '0;
            inflight_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            fill_q     <= fill_d;
            inflight_q <= inflight_d;
        end
    end

    sync_tp_ram_fifo_obuf #(
        .DEPTH      (OB_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (OB_CNT_W)
    ) u_obuf (
        .Clk_CI      (Clk_CI),
        .Rst_RBI     (Rst_RBI),
        .Clr_SI      (Clr_SI),
        .Push_SI     (inflight_q[RAM_LATENCY-1]),
        .PushData_DI (RamRdData_DI),
        .Pop_SI      (out_pop),
        .Cnt_DO      (ob_cnt),
        .HeadData_DO (OutData_DO)
    );

    assign RamWrEn_SO   = in_xfer;
    assign RamWrAddr_DO = wr_ptr_q;
    assign RamWrData_DO = InData_DI;
    assign RamRdEn_SO   = rd_issue;
    assign RamRdAddr_DO = rd_ptr_q;
    assign Fill_DO      = fill_q;

    depth_param_a: assert property (@(posedge Clk_CI)
                                    64'(DATA_DEPTH) <= (64'd1 << ADDR_WIDTH));
    latency_param_a: assert property (@(posedge Clk_CI)
                                      (RAM_LATENCY == RAM_LAT_NO_OREG) ||
                                      (RAM_LATENCY == RAM_LAT_OREG));

endmodule

// File: tb/tb_sync_tp_ram_fifo_ctrl.sv
// Directed bench: two controllers (RAM latency 1 and 2, depth 5) with behavioural RAMs,
// shared stimulus, per-instance scoreboards and hand-computed timing checks.
module tb_sync_tp_ram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_wr_en, a_rd_en;
    logic [31:0] a_out_data, a_wr_data, a_rd_data;
    logic [2:0]  a_wr_addr, a_rd_addr;
    logic [4:0]  a_fill;

    logic        b_in_ready, b_out_valid, b_wr_en, b_rd_en;
    logic [31:0] b_out_data, b_wr_data, b_rd_data, b_rd_s1;
    logic [2:0]  b_wr_addr, b_rd_addr;
    logic [4:0]  b_fill;

    logic [31:0] mem_a [8];
    logic [31:0] mem_b [8];

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    int a_wa, b_wa, a_pushes, b_pushes, a_pops, b_pops;
    int pa, pb, a_gaps, b_gaps;

    always #5 clk = ~clk;

    sync_tp_ram_fifo_ctrl #(
        .ADDR_WIDTH (3), .DATA_DEPTH (5), .DATA_WIDTH (32), .RAM_LATENCY (1)
    ) dut_a (
        .Clk_CI       (clk),
        .Rst_RBI      (rst_n),
        .Clr_SI       (clr),
        .InValid_SI   (in_valid),
        .InReady_SO   (a_in_ready),
        .InData_DI    (in_data),
        .OutValid_SO  (a_out_valid),
        .OutReady_SI  (out_ready),
        .OutData_DO   (a_out_data),
        .RamWrEn_SO   (a_wr_en),
        .RamWrAddr_DO (a_wr_addr),
        .RamWrData_DO (a_wr_data),
        .RamRdEn_SO   (a_rd_en),
        .RamRdAddr_DO (a_rd_addr),
        .RamRdData_DI (a_rd_data),
        .Fill_DO      (a_fill)
    );

    sync_tp_ram_fifo_ctrl #(
        .ADDR_WIDTH (3), .DATA_DEPTH (5), .DATA_WIDTH (32), .RAM_LATENCY (2)
    ) dut_b (
        .Clk_CI       (clk),
        .Rst_RBI      (rst_n),
        .Clr_SI       (clr),
        .InValid_SI   (in_valid),
        .InReady_SO   (b_in_ready),
        .InData_DI    (in_data),
        .OutValid_SO  (b_out_valid),
        .OutReady_SI  (out_ready),
        .OutData_DO   (b_out_data),
        .RamWrEn_SO   (b_wr_en),
        .RamWrAddr_DO (b_wr_addr),
        .RamWrData_DO (b_wr_data),
        .RamRdEn_SO   (b_rd_en),
        .RamRdAddr_DO (b_rd_addr),
        .RamRdData_DI (b_rd_data),
        .Fill_DO      (b_fill)
    );

    // Behavioural RAMs: A has no output register, B has one.
    always @(posedge clk) begin
        if (a_wr_en) mem_a[a_wr_addr] <= a_wr_data;
        if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
        if (b_wr_en) mem_b[b_wr_addr] <= b_wr_data;
        if (b_rd_en) b_rd_s1 <= mem_b[b_rd_addr];
        b_rd_data <= b_rd_s1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboards: fill must equal words accepted but not yet delivered,
    // output data must come out in acceptance order, write addresses wrap at 5.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_a.delete(); a_wa = 0; a_pushes = 0; a_pops = 0;
        end else begin
            chk("a_fill", 64'(a_fill), 64'(exp_a.size()));
            if (a_out_valid && out_ready) begin
                chk("a_pop_nonempty", 64'(exp_a.size() != 0), 64'(1));
                if (exp_a.size() != 0) chk("a_out_data", 64'(a_out_data), 64'(exp_a.pop_front()));
                a_pops++;
            end
            if (a_wr_en) begin
                chk("a_wr_addr", 64'(a_wr_addr), 64'(a_wa));
                chk("a_wr_data", 64'(a_wr_data), 64'(in_data));
                a_wa = (a_wa == 4) ? 0 : a_wa + 1;
                exp_a.push_back(in_data);
                a_pushes++;
            end
            if (clr) begin
                exp_a.delete(); a_wa = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_b.delete(); b_wa = 0; b_pushes = 0; b_pops = 0;
        end else begin
            chk("b_fill", 64'(b_fill), 64'(exp_b.size()));
            if (b_out_valid && out_ready) begin
                chk("b_pop_nonempty", 64'(exp_b.size() != 0), 64'(1));
                if (exp_b.size() != 0) chk("b_out_data", 64'(b_out_data), 64'(exp_b.pop_front()));
                b_pops++;
            end
            if (b_wr_en) begin
                chk("b_wr_addr", 64'(b_wr_addr), 64'(b_wa));
                chk("b_wr_data", 64'(b_wr_data), 64'(in_data));
                b_wa = (b_wa == 4) ? 0 : b_wa + 1;
                exp_b.push_back(in_data);
                b_pushes++;
            end
            if (clr) begin
                exp_b.delete(); b_wa = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("rst_a_in_ready", 64'(a_in_ready), 64'(1));
        chk("rst_a_fill", 64'(a_fill), 64'(0));
        chk("rst_a_wr_en", 64'(a_wr_en), 64'(0));
        chk("rst_a_rd_en", 64'(a_rd_en), 64'(0));
        chk("rst_a_wr_addr", 64'(a_wr_addr), 64'(0));
        chk("rst_a_rd_addr", 64'(a_rd_addr), 64'(0));
        chk("rst_b_out_valid", 64'(b_out_valid), 64'(0));
        chk("rst_b_fill", 64'(b_fill), 64'(0));
        @(posedge clk); #1; rst_n = 1'b1;

        // Single word: cycle 0 write, cycle 1 read issue, valid at 3 (A) / 4 (B)
        cyc(); in_valid = 1'b1; in_data = 32'hDEADBEEF; mid();
        chk("c0_wr_en", 64'(a_wr_en), 64'(1));
        chk("c0_wr_addr", 64'(a_wr_addr), 64'(0));
        chk("c0_wr_data", 64'(a_wr_data), 64'hDEADBEEF);
        cyc(); in_valid = 1'b0; mid();
        chk("c1_rd_en", 64'(a_rd_en), 64'(1));
        chk("c1_rd_addr", 64'(a_rd_addr), 64'(0));
        chk("c1_fill", 64'(a_fill), 64'(1));
        chk("c1_out_valid", 64'(a_out_valid), 64'(0));
        cyc(); mid();
        chk("c2_out_valid", 64'(a_out_valid), 64'(0));
        chk("c2_rd_en", 64'(a_rd_en), 64'(0));
        chk("c2_fill", 64'(a_fill), 64'(1));
        cyc(); mid();
        chk("c3_a_out_valid", 64'(a_out_valid), 64'(1));
        chk("c3_a_out_data", 64'(a_out_data), 64'hDEADBEEF);
        chk("c3_a_fill", 64'(a_fill), 64'(1));
        chk("c3_b_out_valid", 64'(b_out_valid), 64'(0));
        cyc(); out_ready = 1'b1; mid();
        chk("c4_a_out_valid", 64'(a_out_valid), 64'(1));
        chk("c4_b_out_valid", 64'(b_out_valid), 64'(1));
        chk("c4_b_out_data", 64'(b_out_data), 64'hDEADBEEF);
        cyc(); mid();
        chk("c5_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("c5_a_fill", 64'(a_fill), 64'(0));
        chk("c5_b_out_valid", 64'(b_out_valid), 64'(0));
        chk("c5_b_fill", 64'(b_fill), 64'(0));

        // Streaming 0..99 with the consumer always ready: no gaps after the latency
        pa = a_pops; pb = b_pops; a_gaps = 0; b_gaps = 0;
        for (int i = 0; i < 110; i++) begin
            cyc(); in_valid = (i < 100); in_data = 32'(i); mid();
            if (i >= 3 && i <= 102 && !a_out_valid) a_gaps++;
            if (i >= 4 && i <= 103 && !b_out_valid) b_gaps++;
        end
        chk("stream_a_gaps", 64'(a_gaps), 64'(0));
        chk("stream_b_gaps", 64'(b_gaps), 64'(0));
        chk("stream_a_count", 64'(a_pops - pa), 64'(100));
        chk("stream_b_count", 64'(b_pops - pb), 64'(100));

        // Full: depth 5 plus prefetch slots (2 for A, 3 for B)
        out_ready = 1'b0; pa = a_pushes; pb = b_pushes;
        for (int i = 0; i < 15; i++) begin
            cyc(); in_valid = 1'b1; in_data = 32'h100 + 32'(i);
        end
        cyc(); in_valid = 1'b0; mid();
        chk("full_a_accepted", 64'(a_pushes - pa), 64'(7));
        chk("full_b_accepted", 64'(b_pushes - pb), 64'(8));
        chk("full_a_in_ready", 64'(a_in_ready), 64'(0));
        chk("full_b_in_ready", 64'(b_in_ready), 64'(0));
        chk("full_a_fill", 64'(a_fill), 64'(7));
        chk("full_b_fill", 64'(b_fill), 64'(8));
        chk("full_a_out_valid", 64'(a_out_valid), 64'(1));

        // Drain while refilling across the pointer wrap, then drain fully
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc(); in_valid = 1'b1; in_data = 32'h200 + 32'(i);
        end
        cyc(); in_valid = 1'b0;
        repeat (20) cyc();
        mid();
        chk("wrap_a_empty", 64'(exp_a.size()), 64'(0));
        chk("wrap_b_empty", 64'(exp_b.size()), 64'(0));
        chk("wrap_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("wrap_b_fill", 64'(b_fill), 64'(0));

        // Random backpressure on both sides
        for (int i = 0; i < 10000; i++) begin
            cyc();
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
        end
        cyc(); in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) cyc();
        mid();
        chk("rand_a_empty", 64'(exp_a.size()), 64'(0));
        chk("rand_b_empty", 64'(exp_b.size()), 64'(0));
        chk("rand_a_fill", 64'(a_fill), 64'(0));
        chk("rand_b_fill", 64'(b_fill), 64'(0));

        // Clear with A's buffer full and two reads in flight in B
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); in_valid = 1'b1; in_data = 32'h300 + 32'(i);
        end
        cyc(); in_valid = 1'b0; clr = 1'b1; mid();
        chk("clr_a_in_ready", 64'(a_in_ready), 64'(0));
        chk("clr_a_rd_en", 64'(a_rd_en), 64'(0));
        chk("clr_b_rd_en", 64'(b_rd_en), 64'(0));
        chk("clr_a_out_valid", 64'(a_out_valid), 64'(1));
        chk("clr_b_out_valid", 64'(b_out_valid), 64'(1));
        chk("clr_a_fill", 64'(a_fill), 64'(4));
        chk("clr_b_fill", 64'(b_fill), 64'(4));
        cyc(); clr = 1'b0; mid();
        chk("postclr_a_fill", 64'(a_fill), 64'(0));
        chk("postclr_b_fill", 64'(b_fill), 64'(0));
        chk("postclr_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("postclr_b_out_valid", 64'(b_out_valid), 64'(0));
        cyc(); in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
        cyc(); in_valid = 1'b0;
        cyc();
        cyc(); mid();
        chk("clr55_a_out_valid", 64'(a_out_valid), 64'(1));
        chk("clr55_a_out_data", 64'(a_out_data), 64'h55);
        chk("clr55_b_out_valid", 64'(b_out_valid), 64'(0));
        cyc(); mid();
        chk("clr55_b_out_valid2", 64'(b_out_valid), 64'(1));
        chk("clr55_b_out_data", 64'(b_out_data), 64'h55);

        // Asynchronous reset between edges in the middle of a stream
        for (int i = 0; i < 6; i++) begin
            cyc(); in_valid = 1'b1; in_data = 32'h400 + 32'(i);
        end
        @(posedge clk); #3; in_valid = 1'b0; rst_n = 1'b0; #1;
        chk("arst_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("arst_a_fill", 64'(a_fill), 64'(0));
        chk("arst_a_in_ready", 64'(a_in_ready), 64'(1));
        chk("arst_a_wr_en", 64'(a_wr_en), 64'(0));
        chk("arst_a_rd_en", 64'(a_rd_en), 64'(0));
        chk("arst_b_out_valid", 64'(b_out_valid), 64'(0));
        chk("arst_b_fill", 64'(b_fill), 64'(0));
        chk("arst_b_rd_addr", 64'(b_rd_addr), 64'(0));
        @(negedge clk);
        cyc(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(); in_valid = 1'b1; in_data = 32'h500 + 32'(i);
        end
        cyc(); in_valid = 1'b0;
        repeat (8) cyc();
        mid();
        chk("arst_post_a_pops", 64'(a_pops), 64'(4));
        chk("arst_post_b_pops", 64'(b_pops), 64'(4));
        chk("arst_post_a_empty", 64'(exp_a.size()), 64'(0));
        chk("arst_post_b_fill", 64'(b_fill), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
